// File: rtl/sync_fifo_pkg.sv
// Shared types and width helpers for the programmable synchronous FIFO.
// Imported by the pointer sub-module and the FIFO top level.
package sync_fifo_pkg;

  // Smallest width (at least 1) able to index "depth" distinct values.
  function automatic int clog2_depth(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_PTR_W  = clog2_depth(DEF_DEPTH);
  localparam int DEF_CNT_W  = clog2_depth(DEF_DEPTH + 1);

  // Per-cycle operation, encoded as {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Circular pointer register that wraps from DEPTH-1 back to zero.
// Works for any DEPTH >= 2, including non-powers of two.
module fifo_wrap_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PW    = clog2_depth(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // Advance on enable; the last slot rolls over to 0, never to DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with any depth, FWFT or registered read, occupancy
// count, runtime watermarks and sticky overflow/underflow flags.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter bit FWFT   = 1'b1,
  parameter int CW     = clog2_depth(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WR_EN,
  input  logic [DWIDTH-1:0] WR_DATA,
  output logic              FULL,
  output logic              ALMOST_FULL,
  input  logic              RD_EN,
  output logic [DWIDTH-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic              EMPTY,
  output logic              ALMOST_EMPTY,
  input  logic [CW-1:0]     AF_THRESH,
  input  logic [CW-1:0]     AE_THRESH,
  output logic [CW-1:0]     COUNT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
  input  logic              ERR_CLR
);

  localparam int PW = clog2_depth(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf;
  logic              udf;
  fifo_op_e          op;

  // Acceptance looks only at this cycle's FULL/EMPTY, so a pop never
  // makes room for a same-cycle push and vice versa.
  assign wr_acc = WR_EN & ~FULL;
  assign rd_acc = RD_EN & ~EMPTY;
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  assign FULL         = (count == DEPTH_C);
  assign EMPTY        = (count == '0);
  assign ALMOST_FULL  = (count >= AF_THRESH);
  assign ALMOST_EMPTY = (count <= AE_THRESH);
  assign COUNT        = count;
  assign OVERFLOW     = ovf;
  assign UNDERFLOW    = udf;

  fifo_wrap_ptr #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_wptr (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (wr_acc),
    .ptr   (wptr)
  );

  fifo_wrap_ptr #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_rptr (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (rd_acc),
    .ptr   (rptr)
  );

  // Storage write; contents are never reset, only the pointers are.
  always_ff @(posedge CLK) begin
    if (RST_N && wr_acc) begin
      mem[wptr] <= WR_DATA;
    end
  end

  // Occupancy tracks the net effect of accepted push and pop.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count <= '0;
    end else begin
      unique case (op)
        OP_WR:   count <= count + 1'b1;
        OP_RD:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (WR_EN & FULL) | (ovf & ~ERR_CLR);
      udf <= (RD_EN & EMPTY) | (udf & ~ERR_CLR);
    end
  end

  if (FWFT) begin : g_fwft
    assign RD_DATA  = mem[rptr];
    assign RD_VALID = ~EMPTY;
  end else begin : g_reg
    logic [DWIDTH-1:0] rd_q;
    logic              rv_q;

    // Registered read port: load head on pop, valid for one cycle.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        rd_q <= '0;
        rv_q <= 1'b0;
      end else begin
        rv_q <= rd_acc;
        if (rd_acc) rd_q <= mem[rptr];
      end
    end

    assign RD_DATA  = rd_q;
    assign RD_VALID = rv_q;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench: DEPTH=6 FWFT and DEPTH=8 registered-read FIFOs
// against a queue-based reference model plus directed vectors.
module tb_sync_fifo_prog;

  localparam int DA  = 6;
  localparam int DB  = 8;
  localparam int CWA = 3;
  localparam int CWB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           a_rst_n, a_wr, a_rd, a_clr;
  logic [31:0]    a_wd, a_rdata;
  logic           a_full, a_af, a_empty, a_ae, a_valid, a_ovf, a_udf;
  logic [CWA-1:0] a_afth, a_aeth, a_count;

  logic           b_rst_n, b_wr, b_rd, b_clr;
  logic [31:0]    b_wd, b_rdata;
  logic           b_full, b_af, b_empty, b_ae, b_valid, b_ovf, b_udf;
  logic [CWB-1:0] b_afth, b_aeth, b_count;

  sync_fifo_prog #(.DWIDTH(32), .DEPTH(DA), .FWFT(1'b1)) u_a (
    .CLK(clk), .RST_N(a_rst_n), .WR_EN(a_wr), .WR_DATA(a_wd),
    .FULL(a_full), .ALMOST_FULL(a_af), .RD_EN(a_rd),
    .RD_DATA(a_rdata), .RD_VALID(a_valid), .EMPTY(a_empty),
    .ALMOST_EMPTY(a_ae), .AF_THRESH(a_afth), .AE_THRESH(a_aeth),
    .COUNT(a_count), .OVERFLOW(a_ovf), .UNDERFLOW(a_udf),
    .ERR_CLR(a_clr)
  );

  sync_fifo_prog #(.DWIDTH(32), .DEPTH(DB), .FWFT(1'b0)) u_b (
    .CLK(clk), .RST_N(b_rst_n), .WR_EN(b_wr), .WR_DATA(b_wd),
    .FULL(b_full), .ALMOST_FULL(b_af), .RD_EN(b_rd),
    .RD_DATA(b_rdata), .RD_VALID(b_valid), .EMPTY(b_empty),
    .ALMOST_EMPTY(b_ae), .AF_THRESH(b_afth), .AE_THRESH(b_aeth),
    .COUNT(b_count), .OVERFLOW(b_ovf), .UNDERFLOW(b_udf),
    .ERR_CLR(b_clr)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit          ma_ovf, ma_udf, mb_ovf, mb_udf, mb_rv;
  logic [31:0] mb_rd;

  typedef struct {
    bit          wr;
    logic [31:0] wd;
    bit          rd;
    bit          clr;
    int          cnt;
    bit          full;
    bit          empty;
    bit          ovf;
    logic [31:0] data;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_a();
    chk("a_count", 32'(a_count), qa.size());
    chk("a_full", 32'(a_full), 32'(qa.size() == DA));
    chk("a_empty", 32'(a_empty), 32'(qa.size() == 0));
    chk("a_af", 32'(a_af), 32'(qa.size() >= int'(a_afth)));
    chk("a_ae", 32'(a_ae), 32'(qa.size() <= int'(a_aeth)));
    chk("a_ovf", 32'(a_ovf), 32'(ma_ovf));
    chk("a_udf", 32'(a_udf), 32'(ma_udf));
    chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
    if (qa.size() != 0) chk("a_data", a_rdata, qa[0]);
  endtask

  task automatic check_b();
    chk("b_count", 32'(b_count), qb.size());
    chk("b_full", 32'(b_full), 32'(qb.size() == DB));
    chk("b_empty", 32'(b_empty), 32'(qb.size() == 0));
    chk("b_af", 32'(b_af), 32'(qb.size() >= int'(b_afth)));
    chk("b_ae", 32'(b_ae), 32'(qb.size() <= int'(b_aeth)));
    chk("b_ovf", 32'(b_ovf), 32'(mb_ovf));
    chk("b_udf", 32'(b_udf), 32'(mb_udf));
    chk("b_valid", 32'(b_valid), 32'(mb_rv));
    chk("b_data", b_rdata, mb_rd);
  endtask

  task automatic cyc_a(input bit w, input logic [31:0] d,
                       input bit r, input bit c);
    bit ful, emp;
    a_wr = w; a_wd = d; a_rd = r; a_clr = c;
    ful = (qa.size() == DA);
    emp = (qa.size() == 0);
    @(posedge clk); #1;
    ma_ovf = (w && ful) ? 1'b1 : (c ? 1'b0 : ma_ovf);
    ma_udf = (r && emp) ? 1'b1 : (c ? 1'b0 : ma_udf);
    if (r && !emp) void'(qa.pop_front());
    if (w && !ful) qa.push_back(d);
    check_a();
  endtask

  task automatic cyc_b(input bit w, input logic [31:0] d,
                       input bit r, input bit c);
    bit ful, emp;
    b_wr = w; b_wd = d; b_rd = r; b_clr = c;
    ful = (qb.size() == DB);
    emp = (qb.size() == 0);
    @(posedge clk); #1;
    mb_ovf = (w && ful) ? 1'b1 : (c ? 1'b0 : mb_ovf);
    mb_udf = (r && emp) ? 1'b1 : (c ? 1'b0 : mb_udf);
    mb_rv  = r && !emp;
    if (r && !emp) mb_rd = qb.pop_front();
    if (w && !ful) qb.push_back(d);
    check_b();
  endtask

  task automatic rst_a();
    a_rst_n = 1'b0; a_wr = 1'b1; a_wd = 32'hEE; a_rd = 1'b1;
    @(posedge clk); #1;
    a_rst_n = 1'b1; a_wr = 1'b0; a_rd = 1'b0;
    qa.delete(); ma_ovf = 1'b0; ma_udf = 1'b0;
    check_a();
  endtask

  task automatic rst_b();
    b_rst_n = 1'b0; b_wr = 1'b1; b_wd = 32'hEE; b_rd = 1'b1;
    @(posedge clk); #1;
    b_rst_n = 1'b1; b_wr = 1'b0; b_rd = 1'b0;
    qb.delete(); mb_ovf = 1'b0; mb_udf = 1'b0;
    mb_rv = 1'b0; mb_rd = '0;
    check_b();
  endtask

  initial begin
    for (int i = 0; i < 6; i++)
      tv[i] = '{1'b1, 32'hA0 + i, 1'b0, 1'b0, i + 1, i == 5,
                1'b0, 1'b0, 32'hA0};
    tv[6] = '{1'b1, 32'hFF, 1'b0, 1'b0, 6, 1'b1, 1'b0, 1'b1, 32'hA0};
    for (int j = 0; j < 6; j++)
      tv[7 + j] = '{1'b0, 32'h0, 1'b1, 1'b0, 5 - j, 1'b0, j == 5,
                    1'b1, 32'hA1 + j};

    a_rst_n = 1'b0; a_wr = 0; a_rd = 0; a_clr = 0; a_wd = '0;
    b_rst_n = 1'b0; b_wr = 0; b_rd = 0; b_clr = 0; b_wd = '0;
    a_afth = '0; a_aeth = '0; b_afth = '0; b_aeth = '0;
    ma_ovf = 0; ma_udf = 0; mb_ovf = 0; mb_udf = 0;
    mb_rv = 0; mb_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check_a();
    check_b();
    chk("rst_a_af_thr0", 32'(a_af), 32'd1);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    a_afth = 3'd5; a_aeth = 3'd1;

    // Fill, overflow, drain on the FWFT instance
    for (int i = 0; i < 13; i++) begin
      cyc_a(tv[i].wr, tv[i].wd, tv[i].rd, tv[i].clr);
      chk("tv_count", 32'(a_count), tv[i].cnt);
      chk("tv_full", 32'(a_full), 32'(tv[i].full));
      chk("tv_empty", 32'(a_empty), 32'(tv[i].empty));
      chk("tv_ovf", 32'(a_ovf), 32'(tv[i].ovf));
      if (!tv[i].empty) chk("tv_data", a_rdata, tv[i].data);
    end
    cyc_a(0, 0, 0, 1);
    chk("ovf_clr", 32'(a_ovf), 32'd0);

    // Underflow and set-beats-clear
    cyc_a(0, 0, 1, 0);
    chk("udf_set", 32'(a_udf), 32'd1);
    cyc_a(0, 0, 1, 1);
    chk("udf_set_wins", 32'(a_udf), 32'd1);
    cyc_a(0, 0, 0, 1);
    chk("udf_clr", 32'(a_udf), 32'd0);

    // Streaming with preload of 3 across pointer wraps
    for (int i = 0; i < 3; i++) cyc_a(1, 32'hB0 + i, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc_a(1, 32'hC0 + i, 1, 0);
      chk("wrap_count", 32'(a_count), 32'd3);
      chk("wrap_head", a_rdata,
          (i + 1 < 3) ? 32'hB0 + i + 1 : 32'hC0 + i - 2);
      chk("wrap_err", 32'({a_ovf, a_udf}), 32'd0);
    end
    for (int i = 0; i < 3; i++) cyc_a(0, 0, 1, 0);

    // Mid-operation reset on the FWFT instance
    for (int i = 0; i < 5; i++) cyc_a(1, 32'hD0 + i, 0, 0);
    rst_a();
    chk("rsta_count", 32'(a_count), 32'd0);
    chk("rsta_empty", 32'(a_empty), 32'd1);
    chk("rsta_valid", 32'(a_valid), 32'd0);

    // Registered-read latency
    cyc_b(1, 32'h11, 1, 0);
    chk("lat_c1_valid", 32'(b_valid), 32'd0);
    cyc_b(0, 0, 1, 0);
    chk("lat_c2_valid", 32'(b_valid), 32'd1);
    chk("lat_c2_data", b_rdata, 32'h11);
    cyc_b(0, 0, 1, 0);
    chk("lat_c3_valid", 32'(b_valid), 32'd0);
    cyc_b(0, 0, 0, 1);

    // Watermarks, one entry at a time
    b_afth = 4'd4; b_aeth = 4'd1;
    cyc_b(0, 0, 0, 0);
    chk("thr_ae0", 32'(b_ae), 32'd1);
    chk("thr_af0", 32'(b_af), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      cyc_b(1, k, 0, 0);
      chk("thr_ae", 32'(b_ae), 32'(k <= 1));
      chk("thr_af", 32'(b_af), 32'(k >= 4));
    end
    b_afth = 4'd9; #1;
    chk("thr_af_above_depth", 32'(b_af), 32'd0);
    b_afth = 4'd8; #1;
    chk("thr_af_same_cycle", 32'(b_af), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      cyc_b(0, 0, 1, 0);
      chk("drain_b_data", b_rdata, k);
    end

    // Mid-operation reset on the registered-read instance
    for (int i = 0; i < 5; i++) cyc_b(1, 32'hE0 + i, 0, 0);
    cyc_b(0, 0, 1, 0);
    cyc_b(1, 32'hE5, 0, 0);
    rst_b();
    chk("rstb_count", 32'(b_count), 32'd0);
    chk("rstb_empty", 32'(b_empty), 32'd1);
    chk("rstb_valid", 32'(b_valid), 32'd0);

    // Randomised traffic against the queue models
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        a_afth = CWA'($urandom_range(0, 7));
        a_aeth = CWA'($urandom_range(0, 7));
      end
      cyc_a($urandom_range(0, 99) < 55, $urandom,
            $urandom_range(0, 99) < 50, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        b_afth = CWB'($urandom_range(0, 10));
        b_aeth = CWB'($urandom_range(0, 10));
      end
      cyc_b($urandom_range(0, 99) < 50, $urandom,
            $urandom_range(0, 99) < 55, $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
